id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32, 64.
REQ-002 Parameter NREG, default 32, architectural register count; legal values 16, 32.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  IF/ID slot holds an instruction.
REQ-006 in_ready  out  1  stage accepts the instruction this cycle.
REQ-007 instr_i  in  32  instruction word.
REQ-008 pc_i  in  XLEN  instruction PC.
REQ-009 wb_we  in  1  writeback enable.
REQ-010 wb_rd  in  5  writeback register index.
REQ-011 wb_data  in  XLEN  writeback value.
REQ-012 flush  in  1  squash held and incoming instruction (taken branch/jump).
REQ-013 ex_ready  in  1  EX accepts the ID/EX payload.
REQ-014 out_valid  out  1  ID/EX payload valid.
REQ-015 out_rd1, out_rd2, out_imm, out_pc  out  XLEN each  operands, sign-extended immediate, PC.
REQ-016 out_rs1, out_rs2, out_rd  out  5 each  register indices.
REQ-017 out_ctrl  out  ctrl_t  ResultSrc, MemWrite, ALUSrc, RegWrite, ALUControl[4:0], Branch, Jump, illegal.

Function
REQ-018 Instruction accepted when in_valid && in_ready; payload appears on outputs the next cycle (1-cycle latency).
REQ-019 ID/EX register loads when ex_ready || !out_valid; otherwise holds all outputs unchanged.
REQ-020 in_ready = (ex_ready || !out_valid) && !hazard.
REQ-021 Immediate formats I, S, B, U, J, sign-extended to XLEN; RV64 W-ops decoded only when XLEN=64, otherwise illegal.
REQ-022 Register reads of index 0 return zero; reads of index >= NREG return zero and set illegal.
REQ-023 Write-through bypass: if wb_we && wb_rd==rs && rs!=0, operand = wb_data in the same cycle.
REQ-024 Load-use hazard: held payload is a load (ResultSrc=01, out_valid=1) and its out_rd!=0 matches rs1 or rs2 of the decoding instruction -> hazard=1; when EX accepts, out_valid drops for exactly one bubble cycle, then the instruction issues.
REQ-025 Unknown opcode/funct -> out_valid with illegal=1, RegWrite=0, MemWrite=0, Branch=0, Jump=0.
REQ-026 flush: next cycle out_valid=0; in_ready=1 so incoming instruction is consumed and dropped; flush overrides hazard and bubble.
REQ-027 Writeback to index 0 is ignored; simultaneous wb and read of the same register returns wb_data (REQ-023).

Reset
REQ-028 During rst: out_valid=0, all out_* data and out_ctrl zero, hazard=0, all registers zero.
REQ-029 Reset asserted mid-operation discards the held payload and any pending bubble; in_ready=0 while rst=1.

Configuration
REQ-030 Macro ZBA_EN defined: sh1add, sh2add, sh3add, and with XLEN=64 add.uw, sh1add.uw-sh3add.uw, slli.uw decode to dedicated ALUControl codes.
REQ-031 Macro ZBA_EN undefined: those encodings decode as illegal (REQ-025); no Zba logic synthesised.

Structure
REQ-032 Package id_pkg holds ctrl_t struct, alu_op_e (5-bit) enum, imm_src_e enum, result_src_e enum, and opcode localparams.
REQ-033 Register file is sub-module id_regfile (NREG x XLEN, 2 read ports, 1 write port, synchronous write, combinational read with bypass).

Verification
REQ-034 Write x5=0x1234 via wb, then issue addi x6,x5,1 -> out_rd1=0x1234, out_imm=1, RegWrite=1.
REQ-035 wb x7=0xAA and addi x8,x7,0 decoded same cycle -> out_rd1=0xAA (bypass).
REQ-036 ld x9,0(x1) followed by add x10,x9,x9 -> one cycle out_valid=0 between them, in_ready=0 for one cycle.
REQ-037 ex_ready=0 for 3 cycles with valid payload -> outputs stable, in_ready=0; resumes with no loss.
REQ-038 flush with held payload and in_valid=1 -> out_valid=0 next cycle, both instructions dropped.
REQ-039 sh2add x3,x1,x2 (x1=2, x2=8) -> ALUControl=SH2ADD with ZBA_EN; illegal=1 without.

Source files
------------

// File: rtl/id_pkg.sv
// Shared types for the instruction-decode stage: control bundle, ALU/immediate/result
// selectors, opcode constants and the immediate generator.
package id_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_ZBA  = 7'b0010000;
  localparam logic [6:0] F7_ADUW = 7'b0000100;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  typedef enum logic [4:0] {
    ALU_ADD      = 5'd0,
    ALU_SUB      = 5'd1,
    ALU_SLL      = 5'd2,
    ALU_SLT      = 5'd3,
    ALU_SLTU     = 5'd4,
    ALU_XOR      = 5'd5,
    ALU_SRL      = 5'd6,
    ALU_SRA      = 5'd7,
    ALU_OR       = 5'd8,
    ALU_AND      = 5'd9,
    ALU_ADDW     = 5'd10,
    ALU_SUBW     = 5'd11,
    ALU_SLLW     = 5'd12,
    ALU_SRLW     = 5'd13,
    ALU_SRAW     = 5'd14,
    ALU_PASSB    = 5'd15,
    ALU_SH1ADD   = 5'd16,
    ALU_SH2ADD   = 5'd17,
    ALU_SH3ADD   = 5'd18,
    ALU_ADDUW    = 5'd19,
    ALU_SH1ADDUW = 5'd20,
    ALU_SH2ADDUW = 5'd21,
    ALU_SH3ADDUW = 5'd22,
    ALU_SLLIUW   = 5'd23,
    ALU_BEQ      = 5'd24,
    ALU_BNE      = 5'd25,
    ALU_BLT      = 5'd26,
    ALU_BGE      = 5'd27,
    ALU_BLTU     = 5'd28,
    ALU_BGEU     = 5'd29,
    ALU_AUIPC    = 5'd30
  } alu_op_e;

  typedef struct packed {
    result_src_e result_src;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    alu_op_e     alu_control;
    logic        branch;
    logic        jump;
    logic        illegal;
  } ctrl_t;

  // Always produces the 64-bit sign-extended form; narrower datapaths take the low bits.
  function automatic logic [63:0] imm_gen(input logic [31:0] ins, input imm_src_e sel);
    logic [63:0] imm;
    case (sel)
      IMM_S:   imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {{32{ins[31]}}, ins[31:12], 12'b0};
      IMM_J:   imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = {{52{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: NREG x XLEN, two combinational read ports with
// write-through bypass, one synchronous write port. x0 and out-of-range indices read zero.
module id_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  localparam int AW   = $clog2(NREG);
  localparam bit FULL = (NREG == 32);

  logic [XLEN-1:0] regs [NREG];

  // Only 16 or 32 entries are supported, so bit 4 alone marks an index as out of range.
  function automatic logic in_range(input logic [4:0] idx);
    return FULL || !idx[4];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0) && in_range(wb_rd)) begin
      regs[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  always_comb begin
    rd1 = '0;
    if ((rs1 != 5'd0) && in_range(rs1)) begin
      rd1 = (wb_we && (wb_rd == rs1)) ? wb_data : regs[rs1[AW-1:0]];
    end
  end

  always_comb begin
    rd2 = '0;
    if ((rs2 != 5'd0) && in_range(rs2)) begin
      rd2 = (wb_we && (wb_rd == rs2)) ? wb_data : regs[rs2[AW-1:0]];
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with ID/EX pipeline register, load-use interlock and flush.
// Optional Zba decode is enabled by defining ZBA_EN.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_rd1,
  output logic [XLEN-1:0] out_rd2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output ctrl_t           out_ctrl
);

  localparam bit IS64 = (XLEN == 64);
  localparam bit FULL = (NREG == 32);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rd1, rd2;
  logic [63:0]     imm_ext;
  imm_src_e        imm_sel;
  ctrl_t           dec, ctrl_n;
  logic            legal, use_rs1, use_rs2, reg_bad;
  logic            hazard, advance, accept;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd1     (rd1),
    .rd2     (rd2),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  assign imm_ext = imm_gen(instr_i, imm_sel);

  always_comb begin
    dec     = '0;
    imm_sel = IMM_I;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    legal   = 1'b1;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        use_rs1         = 1'b0;
        imm_sel         = IMM_U;
        dec.alu_src     = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_control = (opcode == OPC_LUI) ? ALU_PASSB : ALU_AUIPC;
      end
      OPC_JAL: begin
        use_rs1        = 1'b0;
        imm_sel        = IMM_J;
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
      end
      OPC_JALR: begin
        legal          = (funct3 == 3'b000);
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_PC4;
      end
      OPC_BRANCH: begin
        use_rs2    = 1'b1;
        imm_sel    = IMM_B;
        dec.branch = 1'b1;
        case (funct3)
          3'b000:  dec.alu_control = ALU_BEQ;
          3'b001:  dec.alu_control = ALU_BNE;
          3'b100:  dec.alu_control = ALU_BLT;
          3'b101:  dec.alu_control = ALU_BGE;
          3'b110:  dec.alu_control = ALU_BLTU;
          3'b111:  dec.alu_control = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.result_src = RES_MEM;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
          3'b011, 3'b110:                         legal = IS64;
          default:                                legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        use_rs2       = 1'b1;
        imm_sel       = IMM_S;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        case (funct3)
          3'b000, 3'b001, 3'b010: legal = 1'b1;
          3'b011:                 legal = IS64;
          default:                legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        case (funct3)
          3'b000: dec.alu_control = ALU_ADD;
          3'b010: dec.alu_control = ALU_SLT;
          3'b011: dec.alu_control = ALU_SLTU;
          3'b100: dec.alu_control = ALU_XOR;
          3'b110: dec.alu_control = ALU_OR;
          3'b111: dec.alu_control = ALU_AND;
          3'b001: begin
            dec.alu_control = ALU_SLL;
            legal = (instr_i[31:26] == 6'b000000) && (IS64 || !instr_i[25]);
          end
          default: begin
            dec.alu_control = instr_i[30] ? ALU_SRA : ALU_SRL;
            legal = ((instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000))
                    && (IS64 || !instr_i[25]);
          end
        endcase
      end
      OPC_OP: begin
        use_rs2       = 1'b1;
        dec.reg_write = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: dec.alu_control = ALU_ADD;
          {F7_BASE, 3'b001}: dec.alu_control = ALU_SLL;
          {F7_BASE, 3'b010}: dec.alu_control = ALU_SLT;
          {F7_BASE, 3'b011}: dec.alu_control = ALU_SLTU;
          {F7_BASE, 3'b100}: dec.alu_control = ALU_XOR;
          {F7_BASE, 3'b101}: dec.alu_control = ALU_SRL;
          {F7_BASE, 3'b110}: dec.alu_control = ALU_OR;
          {F7_BASE, 3'b111}: dec.alu_control = ALU_AND;
          {F7_ALT,  3'b000}: dec.alu_control = ALU_SUB;
          {F7_ALT,  3'b101}: dec.alu_control = ALU_SRA;
`ifdef ZBA_EN
          {F7_ZBA,  3'b010}: dec.alu_control = ALU_SH1ADD;
          {F7_ZBA,  3'b100}: dec.alu_control = ALU_SH2ADD;
          {F7_ZBA,  3'b110}: dec.alu_control = ALU_SH3ADD;
`endif
          default:           legal = 1'b0;
        endcase
      end
      OPC_OP_IMM_32: begin
        legal         = IS64;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        case (funct3)
          3'b000: dec.alu_control = ALU_ADDW;
          3'b001: begin
            if (funct7 == F7_BASE) dec.alu_control = ALU_SLLW;
`ifdef ZBA_EN
            else if (instr_i[31:26] == 6'b000010) dec.alu_control = ALU_SLLIUW;
`endif
            else legal = 1'b0;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec.alu_control = ALU_SRLW;
            else if (funct7 == F7_ALT) dec.alu_control = ALU_SRAW;
            else legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        legal         = IS64;
        use_rs2       = 1'b1;
        dec.reg_write = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: dec.alu_control = ALU_ADDW;
          {F7_BASE, 3'b001}: dec.alu_control = ALU_SLLW;
          {F7_BASE, 3'b101}: dec.alu_control = ALU_SRLW;
          {F7_ALT,  3'b000}: dec.alu_control = ALU_SUBW;
          {F7_ALT,  3'b101}: dec.alu_control = ALU_SRAW;
`ifdef ZBA_EN
          {F7_ADUW, 3'b000}: dec.alu_control = ALU_ADDUW;
          {F7_ZBA,  3'b010}: dec.alu_control = ALU_SH1ADDUW;
          {F7_ZBA,  3'b100}: dec.alu_control = ALU_SH2ADDUW;
          {F7_ZBA,  3'b110}: dec.alu_control = ALU_SH3ADDUW;
`endif
          default:           legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Reading a register that does not exist in this configuration is treated like a bad encoding.
  assign reg_bad = !FULL && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));

  always_comb begin
    ctrl_n = dec;
    if (!legal || reg_bad) begin
      ctrl_n         = '0;
      ctrl_n.illegal = 1'b1;
    end
  end

  // Handshake: an instruction moves IF/ID -> ID/EX when in_valid && in_ready; the ID/EX
  // payload moves on when out_valid && ex_ready, and is held unchanged otherwise.
  // A flush squashes both the held payload and the incoming word unconditionally.
  assign hazard  = in_valid && out_valid && (out_ctrl.result_src == RES_MEM)
                   && (out_rd != 5'd0) && ((out_rd == rs1) || (out_rd == rs2));
  assign advance = ex_ready || !out_valid;
  assign in_ready = !rst && (flush || (advance && !hazard));
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rd1   <= '0;
      out_rd2   <= '0;
      out_imm   <= '0;
      out_pc    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_rd    <= '0;
      out_ctrl  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= accept;
      if (accept) begin
        out_rd1  <= rd1;
        out_rd2  <= rd2;
        out_imm  <= imm_ext[XLEN-1:0];
        out_pc   <= pc_i;
        out_rs1  <= rs1;
        out_rs2  <= rs2;
        out_rd   <= rd;
        out_ctrl <= ctrl_n;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: reset, decode/immediates, bypass, load-use bubble,
// stall, flush, illegal decode, Zba (ZBA_EN) and mid-run reset.
module tb_id_stage_pipe;
  import id_pkg::*;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            ex_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_rd1, out_rd2, out_imm, out_pc;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  ctrl_t           out_ctrl;

  int n_vec = 0;
  int n_err = 0;

  id_stage_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr_i   (instr_i),
    .pc_i      (pc_i),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .flush     (flush),
    .ex_ready  (ex_ready),
    .out_valid (out_valid),
    .out_rd1   (out_rd1),
    .out_rd2   (out_rd2),
    .out_imm   (out_imm),
    .out_pc    (out_pc),
    .out_rs1   (out_rs1),
    .out_rs2   (out_rs2),
    .out_rd    (out_rd),
    .out_ctrl  (out_ctrl)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // instruction encoders
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] opc);
    return {imm, r1, f3, d, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [6:0] opc);
    return {f7, r2, r1, f3, d, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
    return {imm[11:5], r2, r1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] d);
    return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'b1101111};
  endfunction

  // driver tasks
  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    wb_we = 1'b1; wb_rd = r; wb_data = d;
    step();
    wb_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins, input logic [63:0] p);
    in_valid = 1'b1; instr_i = ins; pc_i = p;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr_i = '0; pc_i = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_rd1", out_rd1, 0);
    rst = 1'b0;

    wb(5'd1, 64'd2);
    wb(5'd2, 64'd8);
    wb(5'd5, 64'h1234);

    // addi x6,x5,1
    send(enc_i(12'd1, 5'd5, 3'b000, 5'd6, 7'b0010011), 64'h100);
    chk("addi_valid", out_valid, 1);
    chk("addi_rd1", out_rd1, 64'h1234);
    chk("addi_imm", out_imm, 64'd1);
    chk("addi_regwrite", out_ctrl.reg_write, 1);
    chk("addi_rd", out_rd, 5'd6);
    chk("addi_rs1", out_rs1, 5'd5);
    chk("addi_pc", out_pc, 64'h100);

    // wb x7 and addi x8,x7,0 in the same cycle
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 64'hAA;
    send(enc_i(12'd0, 5'd7, 3'b000, 5'd8, 7'b0010011), 64'h104);
    wb_we = 1'b0;
    chk("bypass_rd1", out_rd1, 64'hAA);
    send(enc_i(12'd0, 5'd7, 3'b000, 5'd8, 7'b0010011), 64'h108);
    chk("written_rd1", out_rd1, 64'hAA);

    // write to x0 must not be visible
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
    send(enc_i(12'd0, 5'd0, 3'b000, 5'd11, 7'b0010011), 64'h10C);
    wb_we = 1'b0;
    chk("x0_rd1", out_rd1, 64'd0);

    // immediate formats
    send(enc_i(12'hFFF, 5'd1, 3'b000, 5'd12, 7'b0010011), 64'h110);
    chk("imm_i_neg", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("imm_i_rd1", out_rd1, 64'd2);
    send(enc_s(12'hFF8, 5'd2, 5'd1, 3'b011), 64'h114);
    chk("imm_s", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("sd_memwrite", out_ctrl.mem_write, 1);
    chk("sd_regwrite", out_ctrl.reg_write, 0);
    chk("sd_rd2", out_rd2, 64'd8);
    send(enc_b(13'h1FFC, 5'd2, 5'd1, 3'b000), 64'h118);
    chk("imm_b", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_branch", out_ctrl.branch, 1);
    send({20'h80000, 5'd13, 7'b0110111}, 64'h11C);
    chk("imm_u", out_imm, 64'hFFFF_FFFF_8000_0000);
    send(enc_j(21'h800, 5'd1), 64'h120);
    chk("imm_j", out_imm, 64'h800);
    chk("jal_jump", out_ctrl.jump, 1);
    chk("jal_result", out_ctrl.result_src, 2'b10);

    // ld x9,0(x1) then add x10,x9,x9
    in_valid = 1'b1; instr_i = enc_i(12'd0, 5'd1, 3'b011, 5'd9, 7'b0000011); pc_i = 64'h200;
    step();
    chk("ld_valid", out_valid, 1);
    chk("ld_result", out_ctrl.result_src, 2'b01);
    instr_i = enc_r(7'b0000000, 5'd9, 5'd9, 3'b000, 5'd10, 7'b0110011); pc_i = 64'h204;
    #1;
    chk("lu_in_ready", in_ready, 0);
    step();
    chk("lu_bubble", out_valid, 0);
    chk("lu_ready_after", in_ready, 1);
    step();
    chk("lu_add_valid", out_valid, 1);
    chk("lu_add_rd", out_rd, 5'd10);
    in_valid = 1'b0;

    // EX stall for three cycles
    in_valid = 1'b1; instr_i = enc_i(12'd3, 5'd5, 3'b000, 5'd14, 7'b0010011); pc_i = 64'h300;
    step();
    instr_i = enc_i(12'd7, 5'd0, 3'b000, 5'd15, 7'b0010011); pc_i = 64'h304;
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_rd", out_rd, 5'd14);
      chk("stall_imm", out_imm, 64'd3);
      chk("stall_rd1", out_rd1, 64'h1234);
    end
    ex_ready = 1'b1;
    #1;
    chk("resume_in_ready", in_ready, 1);
    step();
    chk("resume_rd", out_rd, 5'd15);
    chk("resume_imm", out_imm, 64'd7);
    chk("resume_valid", out_valid, 1);

    // flush with a held payload and an incoming instruction
    ex_ready = 1'b0;
    instr_i = enc_i(12'd0, 5'd5, 3'b000, 5'd16, 7'b0010011); pc_i = 64'h308;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 1);
    step();
    flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
    chk("flush_valid", out_valid, 0);
    step();
    chk("flush_valid_2", out_valid, 0);

    // unknown opcode and RV64 W-op
    send(32'hFFFF_FFFF, 64'h400);
    chk("illegal_valid", out_valid, 1);
    chk("illegal_ctrl", out_ctrl, 13'h0001);
    send(enc_i(12'd1, 5'd5, 3'b000, 5'd18, 7'b0011011), 64'h404);
    chk("addiw_illegal", out_ctrl.illegal, 0);
    chk("addiw_regwrite", out_ctrl.reg_write, 1);

    // sh2add x3,x1,x2
    send(enc_r(7'b0010000, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011), 64'h408);
    chk("sh2add_rd1", out_rd1, 64'd2);
    chk("sh2add_rd2", out_rd2, 64'd8);
`ifdef ZBA_EN
    chk("sh2add_alu", out_ctrl.alu_control, 5'd17);
    chk("sh2add_illegal", out_ctrl.illegal, 0);
`else
    chk("sh2add_ctrl", out_ctrl, 13'h0001);
`endif

    // reset in the middle of operation
    in_valid = 1'b1; instr_i = enc_i(12'd0, 5'd5, 3'b000, 5'd17, 7'b0010011); pc_i = 64'h500;
    step();
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rd1", out_rd1, 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_regfile", out_rd1, 64'd0);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
